// File: rtl/slink_rx_reader.sv
// SLINK RX FIFO reader: frames {sop,eop,payload} words into a single-packet buffer and waits for a consumer ack.
// Optional SLINK_RD_CHKSUM_EN: the last two words of a packet carry a 16-bit sum and its complement.
module slink_rx_reader #(
  parameter int MAX_LEN = 512,
  parameter int AW      = 9
) (
  input  logic          clk_125m,
  input  logic          rst_125m,
  input  logic          slink_mm_empty,
  input  logic          slink_mm_dval,
  input  logic [17:0]   slink_mm_data,
  output logic          mm_slink_rdreq,
  output logic          pkt_wr_en,
  output logic [AW-1:0] pkt_wr_addr,
  output logic [15:0]   pkt_wr_data,
  output logic          pkt_done,
  output logic [AW:0]   pkt_len,
  output logic          pkt_err,
  input  logic          pkt_ack,
  output logic [2:0]    dbg_state_o
);

  // Handshake: mm_slink_rdreq pops one word when the FIFO is non-empty; slink_mm_dval marks that word exactly
  // one cycle later and is honoured only while a read is outstanding. pkt_done pulses once; pkt_ack (level or
  // pulse) in WAIT releases the buffer.
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_DROP, S_DONE, S_WAIT} state_t;

  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_LEN);
`ifdef SLINK_RD_CHKSUM_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        rd_pend_q;
  logic        skid_full_q, skid_full_d;
  logic [17:0] skid_q, skid_d;
  logic [AW:0] cnt_q, cnt_d, cnt_inc;
  logic [AW:0] len_q, len_d;
  logic        err_q, err_d;
  logic        in_vld, in_sop, in_eop, rdreq;
  logic [17:0] in_word;
  logic [15:0] in_pay;
  logic        wr_en, chk_bad;
  logic [AW-1:0] wr_addr;

  // A held skid word takes priority; no read is ever in flight while it is full.
  assign in_vld  = ~rst_125m & (skid_full_q | (rd_pend_q & slink_mm_dval));
  assign in_word = skid_full_q ? skid_q : slink_mm_data;
  assign in_sop  = in_word[17];
  assign in_eop  = in_word[16];
  assign in_pay  = in_word[15:0];
  assign cnt_inc = cnt_q + 1'b1;

`ifdef SLINK_RD_CHKSUM_EN
  logic [15:0] sum_all_q, sum_all_d, sum_excl_q, sum_excl_d, prev_q, prev_d;

  always_comb begin
    sum_all_d  = sum_all_q;
    sum_excl_d = sum_excl_q;
    prev_d     = prev_q;
    if (wr_en) begin
      sum_excl_d = (state_q == S_IDLE) ? 16'h0 : sum_all_q;
      sum_all_d  = ((state_q == S_IDLE) ? 16'h0 : sum_all_q) + in_pay;
      prev_d     = in_pay;
    end
  end

  // prev_q is the checksum word, sum_excl_q the sum of everything before it.
  assign chk_bad = (prev_q != sum_excl_q) | (in_pay != ~sum_excl_q);

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      sum_all_q  <= '0;
      sum_excl_q <= '0;
      prev_q     <= '0;
    end else begin
      sum_all_q  <= sum_all_d;
      sum_excl_q <= sum_excl_d;
      prev_q     <= prev_d;
    end
  end
`else
  assign chk_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    err_d       = err_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          skid_full_d = 1'b0;
          if (in_sop) begin
            wr_en = 1'b1;
            cnt_d = (AW+1)'(1);
            if (in_eop) begin
              len_d   = (AW+1)'(1);
              err_d   = CHK_EN;
              state_d = S_DONE;
            end else begin
              state_d = S_RECV;
            end
          end
        end
      end
      S_RECV: begin
        if (in_vld) begin
          if (in_sop) begin
            len_d       = cnt_q;
            err_d       = 1'b1;
            skid_d      = in_word;
            skid_full_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[AW-1:0];
            cnt_d   = cnt_inc;
            if (in_eop) begin
              len_d   = cnt_inc;
              err_d   = chk_bad;
              state_d = S_DONE;
            end else if (cnt_inc == MAX_CNT) begin
              state_d = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        if (in_vld && (in_sop || in_eop)) begin
          len_d   = MAX_CNT;
          err_d   = 1'b1;
          state_d = S_DONE;
          if (in_sop) begin
            skid_d      = in_word;
            skid_full_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: if (pkt_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stop reading the moment a word closes the packet so at most the skid word is ever pending.
  assign rdreq = ~rst_125m & ~slink_mm_empty & ~skid_full_q & (state_d != S_DONE) &
                 ((state_q == S_IDLE) | (state_q == S_RECV) | (state_q == S_DROP));

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      state_q     <= S_IDLE;
      rd_pend_q   <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rdreq;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

  assign mm_slink_rdreq = rdreq;
  assign pkt_wr_en      = wr_en;
  assign pkt_wr_addr    = wr_addr;
  assign pkt_wr_data    = wr_en ? in_pay : 16'h0;
  assign pkt_done       = (state_q == S_DONE);
  assign pkt_len        = len_q;
  assign pkt_err        = err_q;
  assign dbg_state_o    = state_q;

endmodule
